conv3x3_input_loader: RTL and testbench

Upstream feeder for the 3x3 matrix convolution engine. It accepts one 3x3 input matrix as a serial stream of 9 words in row-major order over a valid/ready handshake. It assembles the words into a register bank that drives the engine's nine parallel matrix inputs, pulses start, and holds the matrix stable until the engine reports done. It checks frame framing and runs a done-timeout watchdog.

---
 rtl/conv3x3_input_loader_pkg.sv | 13 +
 rtl/conv3x3_input_loader_if.sv | 26 ++
 rtl/conv3x3_input_loader.sv | 126 ++++++++++++
 tb/tb_conv3x3_input_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_input_loader_pkg.sv
// Shared types and constants for the 3x3 convolution input loader.
// Used by the loader top and its stream interface.
package conv_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int MAT_ELEMS  = 9;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        FILL,
        FIRE,
        WAIT_DONE
    } loader_state_t;
endpackage

// File: rtl/conv3x3_input_loader_if.sv
// Row-major element stream feeding the 3x3 input loader.
// master = producer, slave = loader.
interface conv3x3_input_loader_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/conv3x3_input_loader.sv
// Collects a 9-word stream into a held 3x3 matrix, starts the engine,
// waits for done under a watchdog and flags framing/timeout errors.
module conv3x3_input_loader
    import conv_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    conv3x3_input_loader_if.slave s_in,
    output logic [DATA_W-1:0]   mat_0,
    output logic [DATA_W-1:0]   mat_1,
    output logic [DATA_W-1:0]   mat_2,
    output logic [DATA_W-1:0]   mat_3,
    output logic [DATA_W-1:0]   mat_4,
    output logic [DATA_W-1:0]   mat_5,
    output logic [DATA_W-1:0]   mat_6,
    output logic [DATA_W-1:0]   mat_7,
    output logic [DATA_W-1:0]   mat_8,
    output logic                conv_start,
    input  logic                conv_done,
    output logic                busy,
    output logic                frame_err,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    frame_count
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_ELEMS - 1);

    loader_state_t     state;
    loader_state_t     state_nx;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mat [MAT_ELEMS];
    logic [WD_W-1:0]   wd;
    logic              xfer;
    logic              wd_exp;

    assign xfer   = s_in.in_valid && s_in.in_ready;
    assign wd_exp = (wd == WD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:
                if (xfer && idx == LAST_IDX && s_in.in_last)
                    state_nx = FIRE;
            FIRE:      state_nx = WAIT_DONE;
            WAIT_DONE:
                if (conv_done || wd_exp)
                    state_nx = FILL;
            default:   state_nx = FILL;
        endcase
    end

    always_comb begin
        s_in.in_ready = 1'b0;
        conv_start    = 1'b0;
        busy          = 1'b0;
        unique case (state)
            FILL:      s_in.in_ready = 1'b1;
            FIRE: begin
                conv_start = 1'b1;
                busy       = 1'b1;
            end
            WAIT_DONE: busy = 1'b1;
            default:   ;
        endcase
    end

    // Bad framing always resynchronises to element 0 on the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            wd          <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
            for (int k = 0; k < MAT_ELEMS; k++) mat[k] <= '0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (state == FILL && xfer) begin
                mat[idx] <= s_in.in_data;
                if (idx == LAST_IDX) begin
                    idx       <= '0;
                    frame_err <= !s_in.in_last;
                end else if (s_in.in_last) begin
                    idx       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (state == WAIT_DONE) begin
                wd <= wd + WD_W'(1);
                if (conv_done) begin
                    frame_count <= frame_count + CNT_W'(1);
                    wd          <= '0;
                end else if (wd_exp) begin
                    timeout_err <= 1'b1;
                    wd          <= '0;
                end
            end else begin
                wd <= '0;
            end
        end
    end

    assign mat_0 = mat[0];
    assign mat_1 = mat[1];
    assign mat_2 = mat[2];
    assign mat_3 = mat[3];
    assign mat_4 = mat[4];
    assign mat_5 = mat[5];
    assign mat_6 = mat[6];
    assign mat_7 = mat[7];
    assign mat_8 = mat[8];
endmodule

// File: tb/tb_conv3x3_input_loader.sv
// Self-checking bench for conv3x3_input_loader: frame table plus
// hand-written timeout, done-at-expiry and reset sequences.
module tb_conv3x3_input_loader;
    import conv_pkg::*;

    localparam int DW = 32;
    localparam int TO = 64;
    localparam int CW = 16;
    localparam int NV = 6;

    typedef struct {
        int base;
        int step;
        int n_words;
        int last_at;
        bit gaps;
        int exp_err;
        int exp_start;
    } vec_t;

    typedef struct {
        logic [DW-1:0] m [9];
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          conv_start;
    logic          conv_done;
    logic          busy;
    logic          frame_err;
    logic          timeout_err;
    logic [CW-1:0] frame_count;
    logic [DW-1:0] mat [9];

    conv3x3_input_loader_if #(.DATA_W(DW)) s_if ();

    conv3x3_input_loader #(
        .DATA_W(DW),
        .TIMEOUT_CYC(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_in(s_if),
        .mat_0(mat[0]),
        .mat_1(mat[1]),
        .mat_2(mat[2]),
        .mat_3(mat[3]),
        .mat_4(mat[4]),
        .mat_5(mat[5]),
        .mat_6(mat[6]),
        .mat_7(mat[7]),
        .mat_8(mat[8]),
        .conv_start(conv_start),
        .conv_done(conv_done),
        .busy(busy),
        .frame_err(frame_err),
        .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_start = 0;
    int n_ferr = 0;
    int n_terr = 0;
    int start_cyc = -1;
    int exp_fcnt = 0;
    bit snap_ok = 0;
    logic [DW-1:0] snap [9];
    exp_t sb [$];
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: observe outputs on the falling edge, feed the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (frame_err) n_ferr++;
        if (timeout_err) n_terr++;
        if (conv_start) begin
            n_start++;
            start_cyc = cyc;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_start: got conv_start, expected no start");
            end else begin
                e = sb.pop_front();
                for (int k = 0; k < 9; k++)
                    check($sformatf("mat_%0d", k), mat[k], e.m[k]);
            end
            for (int k = 0; k < 9; k++) snap[k] = mat[k];
            snap_ok = 1;
        end else if (busy && snap_ok) begin
            for (int k = 0; k < 9; k++)
                check($sformatf("mat_hold_%0d", k), mat[k], snap[k]);
        end
        if (busy) check("ready_busy", s_if.in_ready, 1'b0);
        if (!busy) snap_ok = 0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic l,
                             input bit gap);
        int w;
        s_if.in_valid = 1'b0;
        if (gap) repeat ($urandom_range(0, 1)) tick();
        w = 0;
        while (!s_if.in_ready && w < 200) begin
            tick();
            w++;
        end
        if (!s_if.in_ready) check("ready_wait", s_if.in_ready, 1'b1);
        s_if.in_data  = d;
        s_if.in_last  = l;
        s_if.in_valid = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
    endtask

    task automatic push_frame(input int base, input int step);
        exp_t e;
        for (int i = 0; i < 9; i++) e.m[i] = DW'(base + step * i);
        sb.push_back(e);
    endtask

    task automatic send_frame(input int base, input int step, input int n,
                              input int last_at, input bit gap);
        for (int i = 0; i < n; i++)
            send_word(DW'(base + step * i), i == last_at, gap);
    endtask

    task automatic finish_done(input int wait_cyc);
        repeat (wait_cyc) tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        exp_fcnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_mat_%0d", tag, k), mat[k], '0);
        check({tag, "_start"}, conv_start, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ferr"}, frame_err, 1'b0);
        check({tag, "_terr"}, timeout_err, 1'b0);
        check({tag, "_fcnt"}, frame_count, '0);
        check({tag, "_ready"}, s_if.in_ready, 1'b1);
    endtask

    initial begin
        int s0, f0, t0, w;

        vecs[0] = '{1,   1,  9,  8, 1'b0, 0, 1};
        vecs[1] = '{10,  10, 9,  8, 1'b1, 0, 1};
        vecs[2] = '{100, 1,  5,  4, 1'b0, 1, 0};
        vecs[3] = '{9,   -1, 9,  8, 1'b0, 0, 1};
        vecs[4] = '{200, 3,  9, -1, 1'b0, 1, 0};
        vecs[5] = '{32'h7fff_fff0, 5, 9, 8, 1'b1, 0, 1};

        reset         = 1'b1;
        conv_done     = 1'b0;
        s_if.in_data  = '0;
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_init");
        reset = 1'b0;
        tick();
        check("post_rst_ready", s_if.in_ready, 1'b1);

        for (int t = 0; t < NV; t++) begin
            s0 = n_start;
            f0 = n_ferr;
            t0 = n_terr;
            if (vecs[t].exp_start != 0)
                push_frame(vecs[t].base, vecs[t].step);
            send_frame(vecs[t].base, vecs[t].step, vecs[t].n_words,
                       vecs[t].last_at, vecs[t].gaps);
            if (vecs[t].exp_start != 0) begin
                check($sformatf("v%0d_start_lat", t), start_cyc, cyc);
                finish_done(4);
            end else begin
                repeat (2) tick();
            end
            check($sformatf("v%0d_ferr", t), n_ferr - f0, vecs[t].exp_err);
            check($sformatf("v%0d_starts", t), n_start - s0,
                  vecs[t].exp_start);
            check($sformatf("v%0d_terr", t), n_terr - t0, 0);
            check($sformatf("v%0d_fcnt", t), frame_count, exp_fcnt);
            check($sformatf("v%0d_ready", t), s_if.in_ready, 1'b1);
        end

        // Done while idle must not count.
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        tick();
        check("idle_done_fcnt", frame_count, exp_fcnt);

        // Watchdog expiry with done withheld.
        t0 = n_terr;
        push_frame(32'h1000, 7);
        send_frame(32'h1000, 7, 9, 8, 1'b0);
        w = 0;
        while (n_terr == t0 && w < TO + 10) begin
            tick();
            w++;
        end
        check("timeout_lat", w, TO + 1);
        check("timeout_n", n_terr - t0, 1);
        check("timeout_fcnt", frame_count, exp_fcnt);
        check("timeout_ready", s_if.in_ready, 1'b1);
        tick();
        check("timeout_pulse", timeout_err, 1'b0);

        // Done on the expiry cycle wins over the watchdog.
        t0 = n_terr;
        push_frame(32'h2000, 1);
        send_frame(32'h2000, 1, 9, 8, 1'b0);
        finish_done(TO);
        repeat (3) tick();
        check("expiry_done_terr", n_terr - t0, 0);
        check("expiry_done_fcnt", frame_count, exp_fcnt);

        // Reset during the 6th element.
        f0 = n_ferr;
        t0 = n_terr;
        send_frame(32'h50, 1, 5, -1, 1'b0);
        s_if.in_data  = 32'h55;
        s_if.in_valid = 1'b1;
        reset         = 1'b1;
        #1;
        exp_fcnt = 0;
        check_reset_vals("rst_fill");
        s_if.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check("rst_fill_ferr", n_ferr - f0, 0);

        // Reset while waiting for done.
        s0 = n_start;
        push_frame(32'h300, 2);
        send_frame(32'h300, 2, 9, 8, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check_reset_vals("rst_wait");
        tick();
        reset = 1'b0;
        repeat (TO + 5) tick();
        check("rst_wait_starts", n_start - s0, 1);
        check("rst_wait_ferr", n_ferr - f0, 0);
        check("rst_wait_terr", n_terr - t0, 0);
        check("rst_wait_fcnt", frame_count, exp_fcnt);

        // Normal frame after resets.
        push_frame(32'habc0, 16);
        send_frame(32'habc0, 16, 9, 8, 1'b1);
        check("post_rst_start_lat", start_cyc, cyc);
        finish_done(4);
        tick();
        check("post_rst_fcnt", frame_count, exp_fcnt);
        check("post_rst_ready2", s_if.in_ready, 1'b1);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
